// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 subset sequencer: per-state datapath control with a data-memory ready/timeout handshake.
// Optional macro MC_PERF_COUNTERS_EN adds the CNT_W parameter and the CycleCount/RetireCount ports.
module multi_cycle_control #(
  parameter int MEM_TIMEOUT = 15
`ifdef MC_PERF_COUNTERS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [2:0]  State,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  ALUOp,
  output logic        InstrRetired,
  output logic        Illegal,
  output logic        MemFault
`ifdef MC_PERF_COUNTERS_EN
  , output logic [CNT_W-1:0] CycleCount
  , output logic [CNT_W-1:0] RetireCount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_RTYPE, K_IMM, K_LDUR, K_STUR, K_CBZ, K_B, K_ILL
  } kind_t;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcsrc;
    logic       reg2loc;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       retired;
    logic       illegal;
    logic       memfault;
  } ctrl_t;

  // Counter only has to reach MEM_TIMEOUT-1; the fault fires in the cycle it would reach MEM_TIMEOUT.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  function automatic kind_t classify(input logic [10:0] op);
    casez (op)
      11'b10110100???: return K_CBZ;
      11'b000101?????: return K_B;
      11'b1011001000?: return K_IMM;   // ORRI
      11'b11010011011: return K_IMM;   // LSL
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: return K_RTYPE; // ADD, SUB, AND, ORR
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      default:         return K_ILL;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [10:0]   op_q;
  logic [TW-1:0] tmo_cnt;
  kind_t         kind, dec_kind;
  logic          mem_timeout;
  ctrl_t         c;

  assign kind        = classify(op_q);
  assign dec_kind    = classify(Opcode);
  assign mem_timeout = (MEM_TIMEOUT != 0) && (tmo_cnt == TW'(MEM_TIMEOUT - 1)) && !MemReady;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= Opcode;
      if (state != S_MEM)    tmo_cnt <= '0;
      else if (!MemReady)    tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // NOTE: every output and the next state get a default first so no path can infer a latch.
  always_comb begin
    c         = '0;
    state_nxt = state;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      unique case (kind)
        K_RTYPE: c.aluop = 2'b10;
        K_IMM:   begin c.alusrc = 1'b1; c.aluop = 2'b10; end
        K_LDUR:  begin c.alusrc = 1'b1; c.memtoreg = 1'b1; end
        K_STUR:  begin c.alusrc = 1'b1; c.reg2loc = 1'b1; end
        K_CBZ:   begin c.reg2loc = 1'b1; c.aluop = 2'b01; end
        default: ;
      endcase
    end

    case (state)
      S_FETCH: begin
        c.irwrite = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // The latch is not yet loaded, so the illegal check looks at the live opcode.
        if (dec_kind == K_ILL) begin
          c.illegal = 1'b1;
          c.pcwrite = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (kind)
          K_RTYPE, K_IMM: state_nxt = S_WB;
          K_LDUR, K_STUR: state_nxt = S_MEM;
          K_CBZ: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = Zero;
            state_nxt = S_FETCH;
          end
          K_B: begin
            c.pcwrite = 1'b1;
            c.pcsrc   = 1'b1;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        c.memread  = (kind == K_LDUR);
        c.memwrite = (kind == K_STUR);
        if (MemReady) begin
          if (kind == K_LDUR) begin
            state_nxt = S_WB;
          end else begin
            c.pcwrite = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (mem_timeout) begin
          c.memfault = 1'b1;
          state_nxt  = S_FETCH;
        end
      end
      S_WB: begin
        c.regwrite = 1'b1;
        c.pcwrite  = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    c.retired = c.pcwrite & ~c.illegal;
  end

  // Reset forces every enable low at once, so an aborted instruction cannot write anything.
  assign State = Reset ? 3'd0 : state;
  assign {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
          ALUOp, InstrRetired, Illegal, MemFault} = Reset ? '0 : c;

`ifdef MC_PERF_COUNTERS_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CycleCount  <= '0;
      RetireCount <= '0;
    end else begin
      CycleCount <= CycleCount + CNT_W'(1);
      if (InstrRetired) RetireCount <= RetireCount + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus pushes the hand-computed per-cycle control vector, a negedge monitor compares.
module tb_multi_cycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       irw, pcw, pcsrc, r2l, alusrc, m2r, rw, mr, mw;
    logic [1:0] aluop;
    logic       ret, ill, mf;
  } vec_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ORRI = 11'b10110010001;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ILL  = 11'b11111111111;

  localparam vec_t V_RST     = '0;
  localparam vec_t V_FETCH   = '{st:3'd0, irw:1'b1, default:'0};
  localparam vec_t V_DEC     = '{st:3'd1, default:'0};
  localparam vec_t V_ILL     = '{st:3'd1, pcw:1'b1, ill:1'b1, default:'0};
  localparam vec_t V_ALU_EX  = '{st:3'd2, aluop:2'b10, default:'0};
  localparam vec_t V_ALU_WB  = '{st:3'd4, pcw:1'b1, rw:1'b1, aluop:2'b10, ret:1'b1, default:'0};
  localparam vec_t V_IMM_EX  = '{st:3'd2, alusrc:1'b1, aluop:2'b10, default:'0};
  localparam vec_t V_IMM_WB  = '{st:3'd4, pcw:1'b1, alusrc:1'b1, rw:1'b1, aluop:2'b10, ret:1'b1, default:'0};
  localparam vec_t V_LD_EX   = '{st:3'd2, alusrc:1'b1, m2r:1'b1, default:'0};
  localparam vec_t V_LD_MEM  = '{st:3'd3, alusrc:1'b1, m2r:1'b1, mr:1'b1, default:'0};
  localparam vec_t V_LD_WB   = '{st:3'd4, pcw:1'b1, alusrc:1'b1, m2r:1'b1, rw:1'b1, ret:1'b1, default:'0};
  localparam vec_t V_ST_EX   = '{st:3'd2, r2l:1'b1, alusrc:1'b1, default:'0};
  localparam vec_t V_ST_MEM  = '{st:3'd3, r2l:1'b1, alusrc:1'b1, mw:1'b1, default:'0};
  localparam vec_t V_ST_DONE = '{st:3'd3, pcw:1'b1, r2l:1'b1, alusrc:1'b1, mw:1'b1, ret:1'b1, default:'0};
  localparam vec_t V_ST_FLT  = '{st:3'd3, r2l:1'b1, alusrc:1'b1, mw:1'b1, mf:1'b1, default:'0};
  localparam vec_t V_CBZ_T   = '{st:3'd2, pcw:1'b1, pcsrc:1'b1, r2l:1'b1, aluop:2'b01, ret:1'b1, default:'0};
  localparam vec_t V_CBZ_N   = '{st:3'd2, pcw:1'b1, r2l:1'b1, aluop:2'b01, ret:1'b1, default:'0};
  localparam vec_t V_B       = '{st:3'd2, pcw:1'b1, pcsrc:1'b1, ret:1'b1, default:'0};

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic [2:0]  State;
  logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic        InstrRetired, Illegal, MemFault;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] CycleCount, RetireCount;
`endif

  multi_cycle_control #(
    .MEM_TIMEOUT(15)
`ifdef MC_PERF_COUNTERS_EN
    , .CNT_W(32)
`endif
  ) dut (
    .CLK(clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .State(State), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp),
    .InstrRetired(InstrRetired), .Illegal(Illegal), .MemFault(MemFault)
`ifdef MC_PERF_COUNTERS_EN
    , .CycleCount(CycleCount), .RetireCount(RetireCount)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  act, mon_e;
  string mon_t;

  assign act = {State, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemToReg, RegWrite,
                MemRead, MemWrite, ALUOp, InstrRetired, Illegal, MemFault};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check(mon_t, 32'(act), 32'(mon_e));
    end
  end

  task automatic cyc(input logic rst, input logic [10:0] op, input logic z, input logic rdy,
                     input vec_t e, input string t);
    @(posedge clk);
    #1;
    Reset = rst; Opcode = op; Zero = z; MemReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic alu_instr(input logic [10:0] op, input vec_t ex, input vec_t wb, input string n);
    cyc(1'b0, op, 1'b0, 1'b0, V_FETCH, {n, "_fetch"});
    cyc(1'b0, op, 1'b0, 1'b0, V_DEC,   {n, "_decode"});
    cyc(1'b0, op, 1'b0, 1'b0, ex,      {n, "_exec"});
    cyc(1'b0, op, 1'b0, 1'b0, wb,      {n, "_wb"});
  endtask

  task automatic ldur_instr(input int wait_cycles, input string n);
    cyc(1'b0, OP_LDUR, 1'b0, 1'b0, V_FETCH, {n, "_fetch"});
    cyc(1'b0, OP_LDUR, 1'b0, 1'b0, V_DEC,   {n, "_decode"});
    cyc(1'b0, OP_LDUR, 1'b0, 1'b0, V_LD_EX, {n, "_exec"});
    for (int i = 0; i < wait_cycles; i++)
      cyc(1'b0, OP_LDUR, 1'b0, 1'b0, V_LD_MEM, {n, "_mem_wait"});
    cyc(1'b0, OP_LDUR, 1'b0, 1'b1, V_LD_MEM, {n, "_mem_ready"});
    cyc(1'b0, OP_LDUR, 1'b0, 1'b0, V_LD_WB,  {n, "_wb"});
  endtask

  task automatic branch_instr(input logic [10:0] op, input logic z, input vec_t ex, input string n);
    cyc(1'b0, op, 1'b0, 1'b0, V_FETCH, {n, "_fetch"});
    cyc(1'b0, op, 1'b0, 1'b0, V_DEC,   {n, "_decode"});
    cyc(1'b0, op, z,    1'b0, ex,      {n, "_exec"});
  endtask

  initial begin
    repeat (3) cyc(1'b1, '0, 1'b0, 1'b0, V_RST, "reset");

    alu_instr(OP_ADD,  V_ALU_EX, V_ALU_WB, "add");
    alu_instr(OP_SUB,  V_ALU_EX, V_ALU_WB, "sub");
    alu_instr(OP_ORRI, V_IMM_EX, V_IMM_WB, "orri");
    alu_instr(OP_LSL,  V_IMM_EX, V_IMM_WB, "lsl");

    ldur_instr(0, "ldur_fast");
    ldur_instr(2, "ldur_slow");

    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_FETCH,   "stur_fetch");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_DEC,     "stur_decode");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_EX,   "stur_exec");
    cyc(1'b0, OP_STUR, 1'b0, 1'b1, V_ST_DONE, "stur_mem_ready");

    // Memory never answers: 14 waiting cycles, then the fault in the 15th.
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_FETCH, "sturto_fetch");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_DEC,   "sturto_decode");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_EX, "sturto_exec");
    for (int i = 0; i < 14; i++)
      cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_MEM, "sturto_mem_wait");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_FLT, "sturto_fault");

    branch_instr(OP_CBZ, 1'b1, V_CBZ_T, "cbz_taken");
    branch_instr(OP_CBZ, 1'b0, V_CBZ_N, "cbz_not_taken");
    branch_instr(OP_B,   1'b0, V_B,     "b");

    cyc(1'b0, OP_ILL, 1'b0, 1'b0, V_FETCH, "ill_fetch");
    cyc(1'b0, OP_ILL, 1'b0, 1'b0, V_ILL,   "ill_decode");

    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_FETCH,  "sturrst_fetch");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_DEC,    "sturrst_decode");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_EX,  "sturrst_exec");
    cyc(1'b0, OP_STUR, 1'b0, 1'b0, V_ST_MEM, "sturrst_mem");
    cyc(1'b1, OP_STUR, 1'b0, 1'b1, V_RST,    "sturrst_reset");
    alu_instr(OP_ADD, V_ALU_EX, V_ALU_WB, "add_after_reset");

`ifdef MC_PERF_COUNTERS_EN
    cyc(1'b1, '0, 1'b0, 1'b0, V_RST, "perf_reset");
    alu_instr(OP_ADD, V_ALU_EX, V_ALU_WB, "perf_add");
    ldur_instr(0, "perf_ldur");
    branch_instr(OP_B, 1'b0, V_B, "perf_b");
    cyc(1'b0, OP_ADD, 1'b0, 1'b0, V_FETCH, "perf_fetch");
    @(negedge clk);
    #1;
    check("cycle_count",  CycleCount,  32'd12);
    check("retire_count", RetireCount, 32'd3);
`endif

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
